// File: rtl/dspl_pkg.sv
// ============================================================================
// Module      : dspl_pkg
// Description : Shared constants, segment glyph patterns and FSM states for the
//               7-segment scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dspl_pkg;

    localparam int N_DIGITS = 8;

    // Bit positions of each segment inside the active-low dec_cat bus
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Lit-segment patterns, active-high, ordered {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Position of the (single) low bit of an active-low one-hot anode vector
    function automatic logic [2:0] onehot_low_idx(input logic [N_DIGITS-1:0] an_l);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_l[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dspl_scan_decoder_seg7_to_hex.sv
// ============================================================================
// Module      : seg7_to_hex
// Description : Combinational decode of a lit-segment pattern into a hex nibble
//               with legal-glyph and blank flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_hex
    import dspl_pkg::*;
(
    input  logic [6:0] seg,
    output logic       vld,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        vld    = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                vld   = 1'b0;
                blank = 1'b1;
            end
            default:   vld = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dspl_scan_decoder.sv
// ============================================================================
// Module      : dspl_scan_decoder
// Description : Samples a multiplexed active-low 7-segment scan and publishes a
//               coherent 8-digit frame snapshot. Define DSPL_ERR_CNT_EN to add
//               the saturating err_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dspl_scan_decoder
    import dspl_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_DIGITS-1:0]   an,
    input  logic [7:0]            dec_cat,
    output logic [N_DIGITS*4-1:0] digits,
    output logic [N_DIGITS-1:0]   dig_vld,
    output logic [N_DIGITS-1:0]   dp,
    output logic                  frame_done,
    output logic                  seg_err,
`ifdef DSPL_ERR_CNT_EN
    output logic [15:0]           err_cnt,
`endif
    output logic                  stalled
);

    localparam int         TW            = $clog2(TIMEOUT + 1);
    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);
    localparam logic [TW-1:0] c_tmo_max  = TW'(TIMEOUT);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

    logic [N_DIGITS-1:0]   r_an_s1, r_an_s2, r_an_p;
    logic [7:0]            r_cat_s1, r_cat_s2, r_cat_p;
    state_t                r_state;
    logic [3:0]            r_set_cnt;
    logic [N_DIGITS*4-1:0] r_sh_dig;
    logic [N_DIGITS-1:0]   r_sh_vld, r_sh_dp, r_seen;
    logic [TW-1:0]         r_tmo_cnt;

    logic                  w_an_chg, w_cat_chg, w_onehot, w_alloff, w_multi;
    logic                  w_capture, w_mh_evt, w_glyph_err;
    logic [2:0]            w_idx;
    logic [N_DIGITS-1:0]   w_cap_mask;
    logic [6:0]            w_seg;
    logic                  w_vld, w_blank;
    logic [3:0]            w_nib;

    assign w_an_chg    = (r_an_s2 != r_an_p);
    assign w_cat_chg   = (r_cat_s2 != r_cat_p);
    assign w_onehot    = $onehot(~r_an_s2);
    assign w_alloff    = &r_an_s2;
    assign w_multi     = !w_onehot && !w_alloff;
    assign w_idx       = onehot_low_idx(r_an_s2);
    assign w_cap_mask  = N_DIGITS'(1) << w_idx;
    assign w_capture   = (r_state == ST_SETTLE) && !w_an_chg && !w_cat_chg
                         && (r_set_cnt == c_settle_last);
    // A multi-hot anode is reported once per new value, not every cycle it persists
    assign w_mh_evt    = w_multi && w_an_chg;
    assign w_glyph_err = w_capture && !w_vld && !w_blank;
    assign w_seg       = ~{r_cat_s2[SEG_A_BIT], r_cat_s2[SEG_B_BIT], r_cat_s2[SEG_C_BIT],
                           r_cat_s2[SEG_D_BIT], r_cat_s2[SEG_E_BIT], r_cat_s2[SEG_F_BIT],
                           r_cat_s2[SEG_G_BIT]};

    seg7_to_hex u_dec (
        .seg    (w_seg),
        .vld    (w_vld),
        .blank  (w_blank),
        .nibble (w_nib)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an_s1    <= '1;
            r_an_s2    <= '1;
            r_an_p     <= '1;
            r_cat_s1   <= '1;
            r_cat_s2   <= '1;
            r_cat_p    <= '1;
            r_state    <= ST_IDLE;
            r_set_cnt  <= '0;
            r_sh_dig   <= '0;
            r_sh_vld   <= '0;
            r_sh_dp    <= '0;
            r_seen     <= '0;
            r_tmo_cnt  <= '0;
            digits     <= '0;
            dig_vld    <= '0;
            dp         <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            r_an_s1  <= an;
            r_an_s2  <= r_an_s1;
            r_an_p   <= r_an_s2;
            r_cat_s1 <= dec_cat;
            r_cat_s2 <= r_cat_s1;
            r_cat_p  <= r_cat_s2;

            case (r_state)
                ST_IDLE: begin
                    if (w_onehot) begin
                        r_state   <= ST_SETTLE;
                        r_set_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_an_chg || w_cat_chg) begin
                        r_state   <= w_onehot ? ST_SETTLE : ST_IDLE;
                        r_set_cnt <= '0;
                    end else if (w_capture) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_set_cnt <= r_set_cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_an_chg) begin
                        r_state   <= w_onehot ? ST_SETTLE : ST_IDLE;
                        r_set_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_capture) begin
                r_sh_dig[{w_idx, 2'b00} +: 4] <= w_nib;
                r_sh_vld[w_idx]               <= w_vld;
                r_sh_dp[w_idx]                <= ~r_cat_s2[SEG_DP_BIT];
            end

            // Publish reads the shadow before any same-edge capture lands in it
            if (r_seen == '1) begin
                digits     <= r_sh_dig;
                dig_vld    <= r_sh_vld;
                dp         <= r_sh_dp;
                frame_done <= 1'b1;
                r_seen     <= w_capture ? w_cap_mask : '0;
            end else begin
                frame_done <= 1'b0;
                if (w_capture) r_seen <= r_seen | w_cap_mask;
            end

            if (w_mh_evt || w_glyph_err) seg_err <= 1'b1;

            if (w_capture) begin
                r_tmo_cnt <= '0;
                stalled   <= 1'b0;
            end else begin
                if (r_tmo_cnt != c_tmo_max) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                if (r_tmo_cnt >= c_tmo_last) stalled <= 1'b1;
            end
        end
    end

`ifdef DSPL_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if ((w_mh_evt || w_glyph_err) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dspl_scan_decoder.sv
// ============================================================================
// Module      : tb_dspl_scan_decoder
// Description : Directed self-checking bench for the 7-segment scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dspl_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  an;
    logic [7:0]  dec_cat;
    logic [31:0] digits;
    logic [7:0]  dig_vld;
    logic [7:0]  dp;
    logic        frame_done;
    logic        seg_err;
    logic        stalled;
`ifdef DSPL_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int fd_cnt = 0;

    logic [7:0] cat_tbl [16];
    logic [7:0] fr_cat  [8];
    int         fr_len  [8];

    dspl_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .dec_cat    (dec_cat),
        .digits     (digits),
        .dig_vld    (dig_vld),
        .dp         (dp),
        .frame_done (frame_done),
        .seg_err    (seg_err),
`ifdef DSPL_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .stalled    (stalled)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic show(input logic [7:0] a, input logic [7:0] c, input int n);
        an      = a;
        dec_cat = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] vals, input logic [7:0] dps);
        for (int i = 0; i < 8; i++) begin
            fr_cat[i] = cat_tbl[vals[4*i +: 4]] & ~{7'b0, dps[i]};
            fr_len[i] = 10;
        end
    endtask

    task automatic play();
        logic [7:0] a;
        for (int i = 0; i < 8; i++) begin
            a = ~(8'b1 << i);
            show(a, fr_cat[i], fr_len[i]);
        end
        show(8'hFF, 8'hFF, 6);
    endtask

    initial begin
        int k;
        // Active-low dec_cat for 0..F with dp off: {~a..~g, 1}
        cat_tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        rst = 1'b0; an = 8'hFF; dec_cat = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_digits",  digits, 32'h0);
        chk("rst_vld",     {24'h0, dig_vld}, 32'h0);
        chk("rst_dp",      {24'h0, dp}, 32'h0);
        chk("rst_fd",      {31'h0, frame_done}, 32'h0);
        chk("rst_err",     {31'h0, seg_err}, 32'h0);
        chk("rst_stalled", {31'h0, stalled}, 32'h0);
        rst = 1'b1;
        show(8'hFF, 8'hFF, 3);

        // Plain frame 0..7
        load(32'h76543210, 8'h00); play();
        chk("t1_fd",     fd_cnt, 32'd1);
        chk("t1_digits", digits, 32'h76543210);
        chk("t1_vld",    {24'h0, dig_vld}, 32'hFF);
        chk("t1_dp",     {24'h0, dp}, 32'h00);
        chk("t1_err",    {31'h0, seg_err}, 32'h0);

        // Position 3 flashed too briefly: frame must not complete
        load(32'hFEDCBA98, 8'hA5); fr_cat[3] = cat_tbl[0]; fr_len[3] = 2; play();
        chk("t2_nofd",   fd_cnt, 32'd1);
        chk("t2_hold",   digits, 32'h76543210);
        load(32'hFEDCBA98, 8'hA5); play();
        chk("t2_fd",     fd_cnt, 32'd2);
        chk("t2_digits", digits, 32'hFEDCBA98);
        chk("t2_dp",     {24'h0, dp}, 32'hA5);
        chk("t2_vld",    {24'h0, dig_vld}, 32'hFF);
        // Positions 4..7 already pending; scanning 0..3 closes that frame
        load(32'hFEDCBA98, 8'hA5);
        for (int i = 4; i < 8; i++) fr_len[i] = 0;
        play();
        chk("t2_fd2",    fd_cnt, 32'd3);
        chk("t2_dig2",   digits, 32'hFEDCBA98);

        // Blank position 5
        load(32'h76543210, 8'h00); fr_cat[5] = 8'hFF; play();
        chk("t4_fd",     fd_cnt, 32'd4);
        chk("t4_digits", digits, 32'h76043210);
        chk("t4_vld",    {24'h0, dig_vld}, 32'hDF);
        chk("t4_err",    {31'h0, seg_err}, 32'h0);

        // Two anodes low at once
        show(8'hF3, 8'h03, 10); show(8'hFF, 8'hFF, 4);
        chk("t3_err",    {31'h0, seg_err}, 32'h1);
        chk("t3_nofd",   fd_cnt, 32'd4);
        load(32'h76543210, 8'hFF); play();
        chk("t3_fd",     fd_cnt, 32'd5);
        chk("t3_digits", digits, 32'h76543210);
        chk("t3_dp",     {24'h0, dp}, 32'hFF);
        chk("t3_sticky", {31'h0, seg_err}, 32'h1);

        rst = 1'b0; repeat (2) @(negedge clk);
        chk("rst2_err",  {31'h0, seg_err}, 32'h0);
        chk("rst2_dig",  digits, 32'h0);
        rst = 1'b1; show(8'hFF, 8'hFF, 3);

        // All segments plus dp lit is the legal glyph "8."
        load(32'h76543210, 8'h00); fr_cat[0] = 8'h00; play();
        chk("t4b_fd",    fd_cnt, 32'd6);
        chk("t4b_dig",   digits, 32'h76543218);
        chk("t4b_dp",    {24'h0, dp}, 32'h01);
        chk("t4b_err",   {31'h0, seg_err}, 32'h0);
        // Only segment a lit is not a hex glyph
        load(32'h76543210, 8'h00); fr_cat[2] = 8'h7F; play();
        chk("t4c_fd",    fd_cnt, 32'd7);
        chk("t4c_dig",   digits, 32'h76543010);
        chk("t4c_vld",   {24'h0, dig_vld}, 32'hFB);
        chk("t4c_err",   {31'h0, seg_err}, 32'h1);

        // Idle display until the stall flag rises
        show(8'hFF, 8'hFF, TIMEOUT / 2);
        chk("t5_early",  {31'h0, stalled}, 32'h0);
        show(8'hFF, 8'hFF, TIMEOUT);
        chk("t5_stall",  {31'h0, stalled}, 32'h1);
        show(8'hFE, cat_tbl[1], 1);
        chk("t5_still",  {31'h0, stalled}, 32'h1);
        k = 0;
        while (stalled && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_clear",  {31'h0, stalled}, 32'h0);
        show(8'hFF, 8'hFF, 4);

        // Five captures, then reset mid-frame
        load(32'h00054321, 8'h00);
        for (int i = 5; i < 8; i++) fr_len[i] = 0;
        play();
        chk("t6_nofd",   fd_cnt, 32'd7);
        rst = 1'b0; repeat (2) @(negedge clk);
        rst = 1'b1; show(8'hFF, 8'hFF, 3);
        chk("t6_rdig",   digits, 32'h0);
        // Only 5..7 after reset: the pre-reset captures must not complete a frame
        load(32'h89ABCDEF, 8'h3C);
        for (int i = 0; i < 5; i++) fr_len[i] = 0;
        play();
        chk("t6_part",   fd_cnt, 32'd7);
        load(32'h89ABCDEF, 8'h3C); play();
        chk("t6_fd",     fd_cnt, 32'd8);
        chk("t6_digits", digits, 32'h89ABCDEF);
        chk("t6_dp",     {24'h0, dp}, 32'h3C);
        chk("t6_vld",    {24'h0, dig_vld}, 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
